conv_sum_tree_accu: RTL and testbench
=====================================

CONV_SUM_TREE_ACCU -- requirements
Module: conv_sum_tree_accu

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of every partial sum, bias and output word, signed two's complement.
REQ-002 Parameter NUMBER_OF_UNITS, default 11, range 1..64: number of conv-unit outputs reduced per cycle.
REQ-003 Parameter NUMBER_OF_PASSES, default 8, range 1..256: input beats accumulated per output pixel (ceil(IFM_DEPTH/NUMBER_OF_UNITS)).
REQ-004 Parameter TREE_STAGES, derived: $clog2(NUMBER_OF_UNITS), minimum 1.
REQ-005 Ports: one clock; reset is asynchronous and active-high. The clock port is clk and the reset port is reset.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 reset  in  1  asynchronous active-high reset.
REQ-008 in_valid  in  1  unit_data_in holds a valid beat this cycle.
REQ-009 unit_data_in  in  NUMBER_OF_UNITS*DATA_WIDTH  packed unit outputs; unit k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-010 data_bias  in  DATA_WIDTH  bias of the current filter; sampled with the first beat of a pixel.
REQ-011 relu_enable  in  1  apply ReLU to the finished pixel; sampled with the last beat of a pixel.
REQ-012 flush  in  1  synchronous abort of the pixel in progress.
REQ-013 data_out  out  DATA_WIDTH  finished pixel value.
REQ-014 out_valid  out  1  one-cycle pulse, data_out valid.
REQ-015 pass_count  out  $clog2(NUMBER_OF_PASSES+1)  beats accepted for the current pixel.
REQ-016 overflow  out  1  sticky saturation flag.

Function
REQ-017 Adder tree of TREE_STAGES registered levels; each level adds adjacent pairs; an odd leftover operand is registered unchanged to the next level.
REQ-018 A valid bit travels alongside each tree level; tree latency is exactly TREE_STAGES cycles from in_valid to tree-output valid.
REQ-019 The tree runs every cycle with no stall; beats may arrive back-to-back or with any number of idle cycles between them.
REQ-020 Pass counter increments on each tree-output-valid beat.
  - On pass 0: accumulator loads bias + tree sum.
  - On later passes: accumulator loads accumulator + tree sum.
REQ-021 data_bias and relu_enable are delayed through the tree alongside each beat, so that they align with their own beat.
REQ-022 On the beat where the pass count reaches NUMBER_OF_PASSES-1, the result is produced one cycle later.
  - data_out receives the final sum, or max(sum,0) when the aligned relu_enable is 1.
  - out_valid pulses for 1 cycle.
  - The pass counter wraps to 0.
REQ-023 Total latency from the last in_valid beat of a pixel to out_valid is TREE_STAGES+1 cycles.
REQ-024 All additions saturate to the signed DATA_WIDTH range. This applies at every tree level and in the accumulator.
REQ-025 Any saturation event sets overflow. overflow clears only on reset.
REQ-026 NUMBER_OF_PASSES=1: every beat yields an output, and bias is added on that same beat.
REQ-027 flush takes priority over an arriving beat.
  - Clears the pass counter, all tree valid bits and the accumulator.
  - No out_valid is generated for the aborted pixel.
  - A beat presented with flush is discarded.
REQ-028 data_out holds its last value until the next out_valid.

Reset
REQ-029 While reset is high, all of the following are cleared asynchronously:
  - data_out=0, out_valid=0, pass_count=0, overflow=0.
  - All tree valid bits=0 and the accumulator=0.
REQ-030 Reset asserted mid-pixel discards the partial sum. The first valid beat after release is treated as pass 0.

Verification
REQ-031 Defaults; 8 back-to-back beats with all units=1 and bias=5 -> one out_valid 5 cycles after the 8th beat, data_out=93 (8*11+5), pass_count returns to 0.
REQ-032 Same stimulus, all units=-2, bias=0, relu_enable=1 -> data_out=0. With relu_enable=0 -> data_out=-176.
REQ-033 Beats separated by random 0..3 idle cycles -> identical result and latency as REQ-031, measured from the last beat.
REQ-034 Units=0x7FFFFFFF, NUMBER_OF_PASSES=2 -> data_out=0x7FFFFFFF and overflow=1; overflow stays 1 through the following pixels.
REQ-035 Flush after 3 beats, then 8 fresh beats -> exactly one out_valid, with value computed from the fresh beats only.
REQ-036 Reset pulse after 4 beats -> all outputs 0 immediately; the next 8 beats produce one correct pixel.

Source files
------------

// File: rtl/conv_sum_tree_accu.sv
// Saturating pipelined adder tree over NUMBER_OF_UNITS conv-unit outputs, followed by a
// per-pixel accumulator that adds the filter bias, applies optional ReLU and flags overflow.
module conv_sum_tree_accu #(
  parameter int DATA_WIDTH       = 32,
  parameter int NUMBER_OF_UNITS  = 11,
  parameter int NUMBER_OF_PASSES = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  in_valid,
  input  logic [NUMBER_OF_UNITS*DATA_WIDTH-1:0] unit_data_in,
  input  logic [DATA_WIDTH-1:0]                 data_bias,
  input  logic                                  relu_enable,
  input  logic                                  flush,
  output logic [DATA_WIDTH-1:0]                 data_out,
  output logic                                  out_valid,
  output logic [$clog2(NUMBER_OF_PASSES+1)-1:0] pass_count,
  output logic                                  overflow
);

  localparam int TREE_STAGES = (NUMBER_OF_UNITS > 1) ? $clog2(NUMBER_OF_UNITS) : 1;
  localparam int PASS_W      = $clog2(NUMBER_OF_PASSES + 1);
  localparam logic [PASS_W-1:0]     LAST_PASS = PASS_W'(NUMBER_OF_PASSES - 1);
  localparam logic [DATA_WIDTH-1:0] SAT_MAX   = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN   = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Operand count at a given tree level; an odd leftover rides up unchanged.
  function automatic int level_count(input int lvl);
    int n;
    n = NUMBER_OF_UNITS;
    for (int k = 0; k < lvl; k++) n = (n + 1) / 2;
    return n;
  endfunction

  // Two's-complement add clamped to the signed range; returns {saturated, result}.
  function automatic logic [DATA_WIDTH:0] sat_add(input logic [DATA_WIDTH-1:0] a,
                                                  input logic [DATA_WIDTH-1:0] b);
    logic [DATA_WIDTH:0] s;
    s = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) return {1'b1, s[DATA_WIDTH] ? SAT_MIN : SAT_MAX};
    return {1'b0, s[DATA_WIDTH-1:0]};
  endfunction

  logic [TREE_STAGES:1] stage_sat;

  for (genvar s = 0; s <= TREE_STAGES; s++) begin : g_lvl
    localparam int N_OUT = level_count(s);
    logic                  vld;
    logic [DATA_WIDTH-1:0] bias;
    logic                  relu;

    if (s == 0) begin : g_br
      for (genvar i = 0; i < N_OUT; i++) begin : g_op
        logic [DATA_WIDTH-1:0] val;
        assign val = unit_data_in[i*DATA_WIDTH +: DATA_WIDTH];
      end
      // A beat presented together with flush never enters the tree.
      assign vld  = in_valid & ~flush;
      assign bias = data_bias;
      assign relu = relu_enable;
    end else begin : g_br
      localparam int N_IN = level_count(s - 1);
      logic                  vld_d, vld_q;
      logic [DATA_WIDTH-1:0] bias_q;
      logic                  relu_q;
      logic [N_OUT-1:0]      sat_vec;

      for (genvar i = 0; i < N_OUT; i++) begin : g_op
        logic [DATA_WIDTH:0]   sum;
        logic [DATA_WIDTH-1:0] val_d, val_q, val;
        if (2*i + 1 < N_IN) begin : g_pair
          assign sum = sat_add(g_lvl[s-1].g_br.g_op[2*i].val, g_lvl[s-1].g_br.g_op[2*i+1].val);
        end else begin : g_pair
          assign sum = {1'b0, g_lvl[s-1].g_br.g_op[2*i].val};
        end
        assign sat_vec[i] = sum[DATA_WIDTH];
        always_comb begin
          val_d = sum[DATA_WIDTH-1:0];
        end
        // NOTE: tree operands are pure datapath qualified by the valid bit, so they carry no reset.
        always_ff @(posedge clk) begin
          val_q <= val_d;
        end
        assign val = val_q;
      end

      // NOTE: every always_comb output gets a value on all paths, so no latch is inferred.
      always_comb begin
        vld_d = g_lvl[s-1].vld & ~flush;
      end

      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_q <= 1'b0;
        else       vld_q <= vld_d;
      end

      always_ff @(posedge clk) begin
        bias_q <= g_lvl[s-1].bias;
        relu_q <= g_lvl[s-1].relu;
      end

      assign vld          = vld_q;
      assign bias         = bias_q;
      assign relu         = relu_q;
      assign stage_sat[s] = (|sat_vec) & g_lvl[s-1].vld & ~flush;
    end
  end

  logic                  tree_vld, tree_relu;
  logic [DATA_WIDTH-1:0] tree_sum, tree_bias;

  assign tree_vld  = g_lvl[TREE_STAGES].vld;
  assign tree_relu = g_lvl[TREE_STAGES].relu;
  assign tree_bias = g_lvl[TREE_STAGES].bias;
  assign tree_sum  = g_lvl[TREE_STAGES].g_br.g_op[0].val;

  logic [DATA_WIDTH-1:0] acc_d, acc_q, data_out_d, data_out_q;
  logic [PASS_W-1:0]     pass_d, pass_q;
  logic                  out_valid_d, out_valid_q, overflow_d, overflow_q;
  logic [DATA_WIDTH:0]   acc_sum;

  // The first beat of a pixel starts from the bias it travelled with, later beats from the accumulator.
  always_comb begin
    acc_d       = acc_q;
    pass_d      = pass_q;
    data_out_d  = data_out_q;
    out_valid_d = 1'b0;
    overflow_d  = overflow_q | (|stage_sat);
    acc_sum     = sat_add((pass_q == '0) ? tree_bias : acc_q, tree_sum);
    if (flush) begin
      acc_d  = '0;
      pass_d = '0;
    end else if (tree_vld) begin
      overflow_d = overflow_d | acc_sum[DATA_WIDTH];
      acc_d      = acc_sum[DATA_WIDTH-1:0];
      if (pass_q == LAST_PASS) begin
        pass_d      = '0;
        out_valid_d = 1'b1;
        data_out_d  = (tree_relu && acc_sum[DATA_WIDTH-1]) ? '0 : acc_sum[DATA_WIDTH-1:0];
      end else begin
        pass_d = pass_q + PASS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      pass_q      <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      pass_q      <= pass_d;
      data_out_q  <= data_out_d;
      out_valid_q <= out_valid_d;
      overflow_q  <= overflow_d;
    end
  end

  assign data_out   = data_out_q;
  assign out_valid  = out_valid_q;
  assign pass_count = pass_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_conv_sum_tree_accu.sv
// Directed self-checking bench: default instance (11 units, 8 passes) plus a 2-pass
// instance sharing the same stimulus for the saturation scenario.
module tb_conv_sum_tree_accu;

  localparam int DW = 32;
  localparam int N  = 11;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [N*DW-1:0] unit_data_in;
  logic [DW-1:0] data_bias;
  logic          relu_enable;
  logic          flush;

  logic [DW-1:0] data_out, data_out2;
  logic          out_valid, out_valid2, overflow, overflow2;
  logic [3:0]    pass_count;
  logic [1:0]    pass_count2;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int pulses_before = 0;
  int gaps [7] = '{1, 0, 3, 2, 0, 1, 3};

  conv_sum_tree_accu u_dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .unit_data_in (unit_data_in),
    .data_bias    (data_bias),
    .relu_enable  (relu_enable),
    .flush        (flush),
    .data_out     (data_out),
    .out_valid    (out_valid),
    .pass_count   (pass_count),
    .overflow     (overflow)
  );

  conv_sum_tree_accu #(.NUMBER_OF_PASSES(2)) u_p2 (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .unit_data_in (unit_data_in),
    .data_bias    (data_bias),
    .relu_enable  (relu_enable),
    .flush        (flush),
    .data_out     (data_out2),
    .out_valid    (out_valid2),
    .pass_count   (pass_count2),
    .overflow     (overflow2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid === 1'b1) pulses++;
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [DW-1:0] v, input logic [DW-1:0] b, input logic r);
    @(negedge clk);
    in_valid     = 1'b1;
    unit_data_in = {N{v}};
    data_bias    = b;
    relu_enable  = r;
    flush        = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b0;
    end
  endtask

  task automatic pixel(input logic [DW-1:0] v, input logic [DW-1:0] b, input logic r,
                       input bit gapped);
    for (int k = 0; k < 8; k++) begin
      beat(v, b, r);
      if (gapped && k < 7) idle(gaps[k]);
    end
  endtask

  // Called right after the last beat is driven; result must appear exactly 5 cycles later.
  task automatic wait_result(input string tag, input bit sel2, input logic [DW-1:0] exp,
                             input logic [DW-1:0] exp_last);
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (i == 4) begin
        check({tag, "_early_valid"}, sel2 ? 32'(out_valid2) : 32'(out_valid), 32'd0);
        check({tag, "_pass_last"}, sel2 ? 32'(pass_count2) : 32'(pass_count), exp_last);
      end
      if (i == 5) begin
        check({tag, "_valid"}, sel2 ? 32'(out_valid2) : 32'(out_valid), 32'd1);
        check({tag, "_data"}, sel2 ? data_out2 : data_out, exp);
        check({tag, "_pass_wrap"}, sel2 ? 32'(pass_count2) : 32'(pass_count), 32'd0);
      end
      if (i == 6) begin
        check({tag, "_pulse_end"}, sel2 ? 32'(out_valid2) : 32'(out_valid), 32'd0);
        check({tag, "_hold"}, sel2 ? data_out2 : data_out, exp);
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b0;
    unit_data_in = '0;
    data_bias    = '0;
    relu_enable  = 1'b0;
    flush        = 1'b0;

    idle(1);
    check("rst_data_out", data_out, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_pass_count", 32'(pass_count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    idle(1);
    reset = 1'b0;
    idle(1);

    pixel(32'd1, 32'd5, 1'b0, 1'b0);
    wait_result("ones_bias5", 1'b0, 32'd93, 32'd7);

    pixel(32'hFFFF_FFFE, 32'd0, 1'b1, 1'b0);
    wait_result("neg_relu", 1'b0, 32'd0, 32'd7);

    pixel(32'hFFFF_FFFE, 32'd0, 1'b0, 1'b0);
    wait_result("neg_norelu", 1'b0, 32'hFFFF_FF50, 32'd7);

    pixel(32'd1, 32'd5, 1'b0, 1'b1);
    wait_result("gapped", 1'b0, 32'd93, 32'd7);

    // Abort a pixel with one pass accumulated and two beats still in the tree.
    pulses_before = pulses;
    beat(32'd100, 32'd9, 1'b0);
    beat(32'd100, 32'd9, 1'b0);
    beat(32'd100, 32'd9, 1'b0);
    idle(2);
    beat(32'd100, 32'd9, 1'b0);
    check("flush_pass_before", 32'(pass_count), 32'd1);
    flush = 1'b1;
    idle(1);
    check("flush_pass_cleared", 32'(pass_count), 32'd0);
    idle(6);
    check("flush_pass_drained", 32'(pass_count), 32'd0);
    check("flush_no_pulse", 32'(pulses - pulses_before), 32'd0);
    pixel(32'd3, 32'd1, 1'b0, 1'b0);
    wait_result("after_flush", 1'b0, 32'd265, 32'd7);
    check("flush_one_pulse", 32'(pulses - pulses_before), 32'd1);

    // Reset in the middle of a pixel.
    beat(32'd1, 32'd5, 1'b0);
    beat(32'd1, 32'd5, 1'b0);
    beat(32'd1, 32'd5, 1'b0);
    beat(32'd1, 32'd5, 1'b0);
    idle(2);
    check("mid_pass_before_rst", 32'(pass_count), 32'd1);
    check("mid_hold_before_rst", data_out, 32'd265);
    reset = 1'b1;
    #1;
    check("mid_rst_data_out", data_out, 32'd0);
    check("mid_rst_pass_count", 32'(pass_count), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    idle(1);
    reset = 1'b0;
    pixel(32'd2, 32'd7, 1'b0, 1'b0);
    wait_result("after_rst", 1'b0, 32'd183, 32'd7);
    check("pre_sat_overflow", 32'(overflow), 32'd0);
    check("pre_sat_overflow2", 32'(overflow2), 32'd0);

    // Saturation through the tree and the accumulator on the 2-pass instance.
    beat(32'h7FFF_FFFF, 32'd0, 1'b0);
    beat(32'h7FFF_FFFF, 32'd0, 1'b0);
    wait_result("sat", 1'b1, 32'h7FFF_FFFF, 32'd1);
    check("sat_overflow2", 32'(overflow2), 32'd1);
    check("sat_overflow", 32'(overflow), 32'd1);
    beat(32'd1, 32'd0, 1'b0);
    beat(32'd1, 32'd0, 1'b0);
    wait_result("after_sat", 1'b1, 32'd22, 32'd1);
    check("sticky_overflow2", 32'(overflow2), 32'd1);
    check("sticky_overflow", 32'(overflow), 32'd1);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
